// File: rtl/accel_seq.sv
// Job sequencer: buffers operands in a FIFO and walks one memory-mapped accelerator
// through load -> go -> poll -> read, returning each result with a status code.
module accel_seq #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        job_valid,
   input  logic [31:0] job_data,
   output logic        job_ready,
   output logic [1:0]  acc_a,
   output logic        acc_we,
   output logic [31:0] acc_wd,
   input  logic [31:0] acc_rd,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_data,
   output logic [1:0]  res_status,
   output logic        busy
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT);
   localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_GO, S_CLR, S_POLL, S_READ, S_OUT
   } state_t;

   state_t         state;
   logic [31:0]    mem [DEPTH];
   logic [AW-1:0]  wr_ptr, rd_ptr;
   logic [CW-1:0]  count;
   logic [TW-1:0]  tcnt;
   logic           err;
   logic           full, push, pop;

   assign full      = (count == C_FULL);
   assign push      = job_valid && !full;
   assign pop       = (state == S_LOAD);
   assign job_ready = !full;
   assign busy      = (state != S_IDLE) || (count != '0);

   // NOTE: the payload array has no reset; clearing count and pointers is what discards it.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= job_data;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
      end
   end

   // Outputs are registered: each transition loads the values the target state drives.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= S_IDLE;
         acc_a      <= 2'd0;
         acc_we     <= 1'b0;
         acc_wd     <= '0;
         res_valid  <= 1'b0;
         res_data   <= '0;
         res_status <= 2'b00;
         tcnt       <= '0;
         err        <= 1'b0;
      end else begin
         // NOTE: non-blocking throughout, so every branch sees pre-edge values.
         acc_we <= 1'b0;
         acc_wd <= '0;
         case (state)
            S_IDLE: begin
               if (count != '0) begin
                  state  <= S_LOAD;
                  acc_a  <= 2'd0;
                  acc_we <= 1'b1;
                  acc_wd <= mem[rd_ptr];
               end
            end
            S_LOAD: begin
               state  <= S_GO;
               acc_a  <= 2'd1;
               acc_we <= 1'b1;
               acc_wd <= 32'd1;
            end
            S_GO: begin
               state  <= S_CLR;
               tcnt   <= '0;
               acc_a  <= 2'd1;
               acc_we <= 1'b1;
            end
            S_CLR: begin
               state <= S_POLL;
               acc_a <= 2'd2;
            end
            S_POLL: begin
               // A done seen on the last allowed cycle still wins over the timeout.
               if (acc_rd[0]) begin
                  err   <= acc_rd[1];
                  state <= S_READ;
                  acc_a <= 2'd3;
               end else if (tcnt == T_LAST) begin
                  res_data   <= '0;
                  res_status <= 2'b10;
                  res_valid  <= 1'b1;
                  state      <= S_OUT;
                  acc_a      <= 2'd0;
               end else if (tcnt != T_MAX) begin
                  tcnt <= tcnt + TW'(1);
               end
            end
            S_READ: begin
               res_data   <= acc_rd;
               res_status <= {1'b0, err};
               res_valid  <= 1'b1;
               state      <= S_OUT;
               acc_a      <= 2'd0;
            end
            S_OUT: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
               acc_a <= 2'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_accel_seq.sv
// Bench for accel_seq: a behavioural accelerator model plus a job-level scoreboard
// of expected results, latencies and accelerator write traffic.
module tb_accel_seq;

   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        job_valid = 1'b0;
   logic [31:0] job_data = '0;
   logic        res_ready = 1'b0;
   logic        job_ready;
   logic [1:0]  acc_a;
   logic        acc_we;
   logic [31:0] acc_wd;
   logic [31:0] acc_rd;
   logic        res_valid;
   logic [31:0] res_data;
   logic [1:0]  res_status;
   logic        busy;

   accel_seq #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .job_valid(job_valid), .job_data(job_data), .job_ready(job_ready),
      .acc_a(acc_a), .acc_we(acc_we), .acc_wd(acc_wd), .acc_rd(acc_rd),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_status(res_status), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Per-job accelerator behaviour: done first seen on poll number 'need' (0 = never).
   typedef struct packed {
      logic [7:0]  need;
      logic        err;
      logic [31:0] res;
   } beh_t;

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  st;
      logic [31:0] lat;
   } exp_t;

   beh_t        beh_q[$];
   exp_t        exp_q[$];
   int          acc_q[$];
   logic [33:0] wlog[$];

   beh_t cur = '0;
   bit   started = 1'b0;
   int   polls = 0;
   logic done;

   assign done = started && (cur.need != 8'd0) && (polls + 1 >= int'(cur.need));

   always @(posedge clk) begin
      if (acc_we) wlog.push_back({acc_a, acc_wd});
      if (acc_we && acc_a == 2'd1 && acc_wd[0]) begin
         if (beh_q.size() != 0) cur <= beh_q.pop_front();
         else cur <= '0;
         started <= 1'b1;
         polls   <= 0;
      end else if (acc_a == 2'd2) begin
         polls <= polls + 1;
      end
   end

   always_comb begin
      acc_rd = '0;
      if (acc_a == 2'd2) begin
         acc_rd[0] = done;
         acc_rd[1] = cur.err;
      end else if (acc_a == 2'd3) begin
         acc_rd = cur.res;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model_job(input int need, input logic err, input logic [31:0] res);
      exp_t e;
      if (need >= 1 && need <= TIMEOUT) begin
         e.data = res;
         e.st   = {1'b0, err};
         e.lat  = 32'(5 + need);
      end else begin
         e.data = '0;
         e.st   = 2'b10;
         e.lat  = 32'(4 + TIMEOUT);
      end
      return e;
   endfunction

   task automatic push_job(input logic [31:0] op, input int need, input logic err,
                           input logic [31:0] res);
      int n = 0;
      job_valid = 1'b1;
      job_data  = op;
      while (job_ready !== 1'b1 && n < 300) begin
         @(posedge clk); #1; n++;
      end
      if (n == 300) check("push_wait", 64'(job_ready), 64'(1));
      @(posedge clk); #1;
      job_valid = 1'b0;
      beh_q.push_back('{need: 8'(need), err: err, res: res});
      exp_q.push_back(model_job(need, err, res));
      acc_q.push_back(cyc);
   endtask

   task automatic get_result(input string tag, input int hold, input bit chk_lat);
      int   n = 0;
      int   acc_at;
      exp_t e;
      while (res_valid !== 1'b1 && n < 300) begin
         @(posedge clk); #1; n++;
      end
      check({tag, "_valid"}, 64'(res_valid), 64'(1));
      check({tag, "_expected"}, 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
         e      = exp_q.pop_front();
         acc_at = acc_q.pop_front();
         if (chk_lat) check({tag, "_latency"}, 64'(cyc - acc_at), 64'(e.lat));
         for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, 64'(res_valid), 64'(1));
         end
         check({tag, "_data"}, 64'(res_data), 64'(e.data));
         check({tag, "_status"}, 64'(res_status), 64'(e.st));
      end
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
   endtask

   initial begin
      logic [31:0] op;
      logic        rdy;

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      check("rst_job_ready", 64'(job_ready), 64'(1));
      check("rst_res_valid", 64'(res_valid), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_acc_a", 64'(acc_a), 64'(0));
      check("rst_acc_we", 64'(acc_we), 64'(0));
      check("rst_acc_wd", 64'(acc_wd), 64'(0));
      check("rst_res_data", 64'(res_data), 64'(0));
      check("rst_res_status", 64'(res_status), 64'(0));
      reset = 1'b1;
      @(posedge clk); #1;

      // Single job: done on third poll, write sequence and latency
      wlog.delete();
      op = $urandom;
      push_job(op, 3, 1'b0, 32'h0000_0078);
      get_result("single", 0, 1'b1);
      check("single_nwrites", 64'(wlog.size()), 64'(3));
      check("single_wr0", 64'(wlog[0]), 64'({2'd0, op}));
      check("single_wr1", 64'(wlog[1]), 64'({2'd1, 32'd1}));
      check("single_wr2", 64'(wlog[2]), 64'({2'd1, 32'd0}));
      check("single_idle_busy", 64'(busy), 64'(0));

      // Accelerator error
      push_job($urandom, 2, 1'b1, 32'hFFFF_FFFF);
      get_result("err", 0, 1'b1);

      // Timeout, done exactly on the last allowed poll, just-too-late done, normal job
      push_job($urandom, 0, 1'b0, $urandom);
      push_job($urandom, TIMEOUT, 1'b0, $urandom);
      push_job($urandom, TIMEOUT + 1, 1'b1, $urandom);
      push_job($urandom, int'($urandom_range(1, 4)), 1'(($urandom_range(0, 1))), $urandom);
      get_result("tmo", 0, 1'b1);
      get_result("tmo_edge", 0, 1'b0);
      get_result("tmo_late", 0, 1'b0);
      get_result("tmo_next", 0, 1'b0);

      // Backpressure: offer 6 jobs on consecutive cycles with res_ready low
      for (int i = 0; i < 6; i++) begin
         logic [7:0]  nd;
         logic        er;
         logic [31:0] rs;
         nd = 8'($urandom_range(1, 4));
         er = 1'($urandom_range(0, 1));
         rs = $urandom;
         job_valid = 1'b1;
         job_data  = $urandom;
         rdy = job_ready;
         check("fifo_ready", 64'(rdy), 64'(i < 5));
         @(posedge clk); #1;
         if (rdy) begin
            beh_q.push_back('{need: nd, err: er, res: rs});
            exp_q.push_back(model_job(int'(nd), er, rs));
            acc_q.push_back(cyc);
         end
      end
      job_valid = 1'b0;
      check("fifo_full_ready", 64'(job_ready), 64'(0));
      check("fifo_busy", 64'(busy), 64'(1));
      get_result("fifo0", 4, 1'b1);
      for (int i = 1; i < 5; i++) get_result("fifo", 0, 1'b0);
      check("fifo_drained", 64'(exp_q.size()), 64'(0));

      // Reset pulsed during POLL with two jobs queued
      push_job($urandom, 0, 1'b0, $urandom);
      push_job($urandom, 0, 1'b0, $urandom);
      push_job($urandom, 0, 1'b0, $urandom);
      for (int n = 0; n < 50 && acc_a !== 2'd2; n++) begin
         @(posedge clk); #1;
      end
      check("rst_mid_in_poll", 64'(acc_a), 64'(2));
      reset = 1'b0;
      @(posedge clk); #1;
      check("rst_mid_job_ready", 64'(job_ready), 64'(1));
      check("rst_mid_busy", 64'(busy), 64'(0));
      check("rst_mid_res_valid", 64'(res_valid), 64'(0));
      check("rst_mid_acc_we", 64'(acc_we), 64'(0));
      check("rst_mid_acc_a", 64'(acc_a), 64'(0));
      reset = 1'b1;
      beh_q.delete();
      exp_q.delete();
      acc_q.delete();
      wlog.delete();
      repeat (20) begin
         @(posedge clk); #1;
      end
      check("rst_mid_no_writes", 64'(wlog.size()), 64'(0));
      check("rst_mid_still_idle", 64'(busy), 64'(0));

      // Pointer wrap over 3*DEPTH jobs with overlapping push/pop and random consumer
      wlog.delete();
      fork
         begin
            for (int i = 1; i <= 3 * DEPTH; i++)
               push_job(32'(i), int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)), $urandom);
         end
         begin
            for (int j = 0; j < 3 * DEPTH; j++) begin
               repeat ($urandom_range(0, 3)) begin
                  @(posedge clk); #1;
               end
               get_result("wrap", 0, 1'b0);
            end
         end
      join
      check("wrap_nwrites", 64'(wlog.size()), 64'(9 * DEPTH));
      for (int i = 0; i < 3 * DEPTH; i++) begin
         check("wrap_wr_op", 64'(wlog[3 * i]), 64'({2'd0, 32'(i + 1)}));
         check("wrap_wr_go", 64'(wlog[3 * i + 1]), 64'({2'd1, 32'd1}));
         check("wrap_wr_clr", 64'(wlog[3 * i + 2]), 64'({2'd1, 32'd0}));
      end
      @(posedge clk); #1;
      check("end_busy", 64'(busy), 64'(0));
      check("end_job_ready", 64'(job_ready), 64'(1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (observed cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
